stream_min_filter: RTL and testbench

STREAM_MIN_FILTER -- requirements
Module: stream_min_filter

---
 rtl/stream_min_filter_if.sv | 23 ++
 rtl/stream_min_filter.sv | 73 +++++++
 tb/tb_stream_min_filter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_min_filter_if.sv
// stream_min_filter_if: pixel stream in (multi-channel) and dark-channel minimum stream out
interface stream_min_filter_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic                     in_sol;
  logic                     in_eol;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_eol;
  modport slave (
    input  in_valid, in_data, in_sol, in_eol, out_ready,
    output in_ready, out_valid, out_data, out_eol
  );
  modport master (
    output in_valid, in_data, in_sol, in_eol, out_ready,
    input  in_ready, out_valid, out_data, out_eol
  );
endinterface

// File: rtl/stream_min_filter.sv
// stream_min_filter: per-pixel channel minimum followed by a line-bounded trailing window minimum
module stream_min_filter #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3,
  parameter int WIN    = 15
) (
  input logic               clk,
  input logic               rst_n,
  stream_min_filter_if.slave s
);
  localparam int FW = $clog2(WIN + 1);
  logic              adv;
  logic [DATA_W-1:0] ch_min;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_min;
  logic              s1_sol;
  logic              s1_eol;
  logic [DATA_W-1:0] win_q [WIN];
  logic [DATA_W-1:0] win_d [WIN];
  logic [FW-1:0]     fill_q;
  logic [FW-1:0]     fill_d;
  logic [DATA_W-1:0] win_min;
  assign adv = !s.out_valid || s.out_ready;
  assign s.in_ready = adv;
  // unsigned minimum across the channels of the incoming pixel
  always_comb begin
    ch_min = s.in_data[DATA_W-1:0];
    for (int k = 1; k < NUM_CH; k++)
      ch_min = s.in_data[k*DATA_W +: DATA_W] < ch_min ? s.in_data[k*DATA_W +: DATA_W] : ch_min;
  end
  // window after inserting the S1 minimum; a line start flushes older pixels to all-ones
  always_comb begin
    win_d[0] = s1_min;
    for (int i = 1; i < WIN; i++)
      win_d[i] = s1_sol ? '1 : win_q[i-1];
    fill_d = s1_sol ? FW'(1) : (fill_q == FW'(WIN) ? fill_q : fill_q + 1'b1);
    win_min = '1;
    for (int i = 0; i < WIN; i++)
      win_min = (FW'(i) < fill_d && win_d[i] < win_min) ? win_d[i] : win_min;
  end
  // S1: capture channel minimum and line flags; a non-accepted cycle loads a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_min   <= '0;
      s1_sol   <= 1'b0;
      s1_eol   <= 1'b0;
    end else if (adv) begin
      s1_valid <= s.in_valid;
      s1_min   <= ch_min;
      s1_sol   <= s.in_sol;
      s1_eol   <= s.in_eol;
    end
  end
  // S2: commit window and register the windowed minimum; everything freezes under stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_eol   <= 1'b0;
      fill_q      <= '0;
      for (int i = 0; i < WIN; i++) win_q[i] <= '1;
    end else if (adv) begin
      s.out_valid <= s1_valid;
      if (s1_valid) begin
        win_q      <= win_d;
        fill_q     <= fill_d;
        s.out_data <= win_min;
        s.out_eol  <= s1_eol;
      end
    end
  end
endmodule

// File: tb/tb_stream_min_filter.sv
// tb_stream_min_filter: directed and random checks of WIN=3 and WIN=15 instances fed the same stream
module tb_stream_min_filter;
  localparam int DW = 8;
  localparam int NC = 3;
  typedef struct {
    logic [NC*DW-1:0] d;
    logic             sol;
    logic             eol;
  } beat_t;
  typedef struct {
    int   ea;
    int   eb;
    logic eol;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             v, sol, eol, ordy;
  logic [NC*DW-1:0] d;

  stream_min_filter_if #(.DATA_W(DW), .NUM_CH(NC)) ia ();
  stream_min_filter_if #(.DATA_W(DW), .NUM_CH(NC)) ib ();
  assign ia.in_valid  = v;
  assign ia.in_data   = d;
  assign ia.in_sol    = sol;
  assign ia.in_eol    = eol;
  assign ia.out_ready = ordy;
  assign ib.in_valid  = v;
  assign ib.in_data   = d;
  assign ib.in_sol    = sol;
  assign ib.in_eol    = eol;
  assign ib.out_ready = ordy;

  stream_min_filter #(.DATA_W(DW), .NUM_CH(NC), .WIN(3)) dut_a (.clk(clk), .rst_n(rst_n), .s(ia));
  stream_min_filter #(.DATA_W(DW), .NUM_CH(NC), .WIN(15)) dut_b (.clk(clk), .rst_n(rst_n), .s(ib));

  beat_t src[$];
  exp_t  expq[$];
  int    cq[$];
  logic  rq[$];
  int    ln[$];
  bit    fresh = 1'b1;
  bit    rnd_v = 1'b0;
  bit    rnd_r = 1'b0;
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input int m, input bit s_, input bit e_);
    beat_t b;
    int j = $urandom_range(NC - 1, 0);
    for (int k = 0; k < NC; k++)
      b.d[k*DW +: DW] = (k == j) ? DW'(m) : DW'($urandom_range(255, m));
    b.sol = s_;
    b.eol = e_;
    return b;
  endfunction

  function automatic int chmin(input logic [NC*DW-1:0] x);
    int r = 255;
    for (int k = 0; k < NC; k++)
      if (int'(x[k*DW +: DW]) < r) r = int'(x[k*DW +: DW]);
    return r;
  endfunction

  function automatic int winmin(input int w);
    int r = 255;
    for (int i = 0; i < w && i < ln.size(); i++)
      if (ln[ln.size()-1-i] < r) r = ln[ln.size()-1-i];
    return r;
  endfunction

  task automatic model_accept(input beat_t b);
    exp_t e;
    if (b.sol || fresh) ln.delete();
    fresh = 1'b0;
    ln.push_back(chmin(b.d));
    if (ln.size() > 15) void'(ln.pop_front());
    e.ea  = winmin(3);
    e.eb  = winmin(15);
    e.eol = b.eol;
    expq.push_back(e);
  endtask

  task automatic run(input int budget, output int used);
    logic            stalled = 1'b0;
    logic [DW-1:0]   pd = '0;
    logic            pe = 1'b0;
    exp_t            e;
    used = 0;
    while ((src.size() != 0 || expq.size() != 0) && used < budget) begin
      if (src.size() != 0) begin
        v   = rnd_v ? ($urandom_range(3, 0) != 0) : 1'b1;
        d   = src[0].d;
        sol = src[0].sol;
        eol = src[0].eol;
      end else begin
        v   = 1'b0;
        sol = 1'b0;
        eol = 1'b0;
      end
      ordy = rq.size() != 0 ? rq.pop_front() : (rnd_r ? ($urandom_range(2, 0) != 0) : 1'b1);
      #1;
      chk("in_ready", ia.in_ready, !ia.out_valid || ordy);
      chk("valid_ab", ib.out_valid, ia.out_valid);
      if (stalled) begin
        chk("hold_valid", ia.out_valid, 1);
        chk("hold_data", ia.out_data, pd);
        chk("hold_eol", ia.out_eol, pe);
      end
      stalled = ia.out_valid && !ordy;
      pd = ia.out_data;
      pe = ia.out_eol;
      if (ia.out_valid && ordy) begin
        if (expq.size() == 0) chk("extra_beat", ia.out_valid, 0);
        else begin
          e = expq.pop_front();
          chk("data_w3", ia.out_data, e.ea);
          chk("data_w15", ib.out_data, e.eb);
          chk("eol_w3", ia.out_eol, e.eol);
          chk("eol_w15", ib.out_eol, e.eol);
          if (cq.size() != 0) chk("directed_w3", ia.out_data, cq.pop_front());
        end
      end
      if (v && ia.in_ready) model_accept(src.pop_front());
      used++;
      @(negedge clk);
    end
    v = 1'b0;
    ordy = 1'b1;
    chk("drained", src.size() + expq.size(), 0);
    chk("directed_left", cq.size(), 0);
  endtask

  initial begin
    beat_t b;
    int    n;
    int    w[$];
    v = 1'b0; sol = 1'b0; eol = 1'b0; d = '0; ordy = 1'b1;
    #1;
    chk("rst_valid", ia.out_valid, 0);
    chk("rst_data", ia.out_data, 0);
    chk("rst_eol", ia.out_eol, 0);
    chk("rst_ready", ia.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_rst", ia.in_ready, 1);
    // single-pixel line: channels A=240, B=166, C=85
    d = {8'd85, 8'd166, 8'd240}; sol = 1'b1; eol = 1'b1; v = 1'b1;
    @(negedge clk);
    v = 1'b0;
    #1 chk("lat1_valid", ia.out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat2_valid", ia.out_valid, 1);
    chk("px_data_w3", ia.out_data, 85);
    chk("px_data_w15", ib.out_data, 85);
    chk("px_eol", ia.out_eol, 1);
    @(negedge clk);
    // sliding window
    w = '{50, 20, 90, 80, 70, 10};
    foreach (w[i]) src.push_back(mk(w[i], i == 0, i == 5));
    cq = '{50, 20, 20, 20, 70, 10};
    run(50, n);
    chk("throughput", n, 8);
    // line boundary, then equal values
    src.push_back(mk(7, 1, 0));
    src.push_back(mk(5, 0, 1));
    src.push_back(mk(200, 1, 0));
    src.push_back(mk(100, 0, 1));
    b.d = {3{8'd77}}; b.sol = 1'b1; b.eol = 1'b0;
    src.push_back(b);
    src.push_back(mk(77, 0, 0));
    src.push_back(mk(255, 0, 1));
    src.push_back(mk(0, 1, 1));
    cq = '{7, 5, 200, 100, 77, 77, 77, 0};
    run(100, n);
    // backpressure: four stalled cycles once out_valid is up
    src.push_back(mk(30, 1, 0));
    src.push_back(mk(10, 0, 0));
    src.push_back(mk(40, 0, 1));
    cq = '{30, 10, 10};
    rq = '{0, 0, 0, 0, 0, 0};
    run(50, n);
    // reset mid-line
    b = mk(3, 1, 0); d = b.d; sol = 1'b1; eol = 1'b0; v = 1'b1;
    @(negedge clk);
    b = mk(3, 0, 0); d = b.d; sol = 1'b0;
    @(negedge clk);
    v = 1'b0;
    #1 chk("pre_rst_valid", ia.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ia.out_valid, 0);
    chk("mid_rst_valid_w15", ib.out_valid, 0);
    chk("mid_rst_data", ia.out_data, 0);
    chk("mid_rst_ready", ia.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expq.delete();
    ln.delete();
    fresh = 1'b1;
    src.push_back(mk(100, 0, 1));
    cq = '{100};
    run(50, n);
    // random stream with random valid/ready
    rnd_v = 1'b1;
    rnd_r = 1'b1;
    for (int i = 0; i < 400; i++)
      src.push_back(mk($urandom_range(255, 0), $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0));
    run(6000, n);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
